// File: rtl/polyvec_ram_arb.sv
// Two-requester round-robin arbiter that streams whole polynomials
// (2^BEAT_BITS RAM words of four coefficients each) into or out of a shared RAM.
module polyvec_ram_arb #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 23,
    parameter int BEAT_BITS  = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic                             cmda_valid,
    output logic                             cmda_ready,
    input  logic                             cmda_we,
    input  logic [ADDR_WIDTH-BEAT_BITS-1:0]  cmda_poly,
    input  logic [4*DATA_WIDTH-1:0]          wda_data,
    input  logic                             wda_valid,
    output logic                             wda_ready,

    input  logic                             cmdb_valid,
    output logic                             cmdb_ready,
    input  logic                             cmdb_we,
    input  logic [ADDR_WIDTH-BEAT_BITS-1:0]  cmdb_poly,
    input  logic [4*DATA_WIDTH-1:0]          wdb_data,
    input  logic                             wdb_valid,
    output logic                             wdb_ready,

    output logic [4*DATA_WIDTH-1:0]          rd_data,
    output logic                             rd_valid,
    output logic                             rd_id,

    output logic                             done,
    output logic                             done_id,
    output logic                             busy,

    output logic                             ram_wen,
    output logic [ADDR_WIDTH-1:0]            ram_waddr,
    output logic [4*DATA_WIDTH-1:0]          ram_din,
    output logic [ADDR_WIDTH-1:0]            ram_raddr,
    input  logic [4*DATA_WIDTH-1:0]          ram_dout
);

    localparam int W  = 4 * DATA_WIDTH;
    localparam int PW = ADDR_WIDTH - BEAT_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t              state, state_next;
    logic                owner, owner_next;
    logic [PW-1:0]       poly, poly_next;
    logic [BEAT_BITS-1:0] beat, beat_next;
    logic                last_b, last_b_next;
    logic                done_next;
    logic                wd_valid_sel;
    logic [W-1:0]        wd_data_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // last_b resets high so requester a wins the first tie.
    always_comb begin
        state_next   = state;
        owner_next   = owner;
        poly_next    = poly;
        beat_next    = beat;
        last_b_next  = last_b;
        done_next    = 1'b0;
        cmda_ready   = 1'b0;
        cmdb_ready   = 1'b0;
        wda_ready    = 1'b0;
        wdb_ready    = 1'b0;
        ram_wen      = 1'b0;
        ram_waddr    = '0;
        ram_raddr    = '0;
        ram_din      = '0;
        wd_valid_sel = owner ? wdb_valid : wda_valid;
        wd_data_sel  = owner ? wdb_data  : wda_data;

        case (state)
            IDLE: begin
                cmda_ready = cmda_valid && (!cmdb_valid || last_b);
                cmdb_ready = cmdb_valid && (!cmda_valid || !last_b);
                if (cmda_ready) begin
                    owner_next  = 1'b0;
                    poly_next   = cmda_poly;
                    beat_next   = '0;
                    last_b_next = 1'b0;
                    state_next  = cmda_we ? WR : RD;
                end else if (cmdb_ready) begin
                    owner_next  = 1'b1;
                    poly_next   = cmdb_poly;
                    beat_next   = '0;
                    last_b_next = 1'b1;
                    state_next  = cmdb_we ? WR : RD;
                end
            end

            WR: begin
                wda_ready = !owner;
                wdb_ready = owner;
                ram_waddr = {poly, beat};
                if (wd_valid_sel) begin
                    ram_wen   = 1'b1;
                    ram_din   = wd_data_sel;
                    beat_next = beat + 1'b1;
                    if (&beat) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            RD: begin
                ram_raddr = {poly, beat};
                beat_next = beat + 1'b1;
                if (&beat) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read data is captured one cycle after its address, so done lines up with the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= 1'b0;
            poly     <= '0;
            beat     <= '0;
            last_b   <= 1'b1;
            done     <= 1'b0;
            done_id  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_id    <= 1'b0;
        end else begin
            owner    <= owner_next;
            poly     <= poly_next;
            beat     <= beat_next;
            last_b   <= last_b_next;
            done     <= done_next;
            rd_valid <= (state == RD);
            if (done_next) begin
                done_id <= owner;
            end
            if (state == RD) begin
                rd_data <= ram_dout;
                rd_id   <= owner;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_polyvec_ram_arb.sv
// Directed bench for polyvec_ram_arb: idle arbitration table plus scripted
// write, stalled write, back-to-back read and mid-read reset sequences.
module tb_polyvec_ram_arb;

    localparam int AW = 8;
    localparam int DW = 23;
    localparam int BB = 6;
    localparam int W  = 4 * DW;
    localparam int PW = AW - BB;

    localparam logic [W-1:0] DATA_A = 92'h5_A000_0000;
    localparam logic [W-1:0] DATA_C = 92'h3_C000_0000;

    logic          clk;
    logic          rst_n;
    logic          cmda_valid, cmda_ready, cmda_we;
    logic [PW-1:0] cmda_poly;
    logic [W-1:0]  wda_data;
    logic          wda_valid, wda_ready;
    logic          cmdb_valid, cmdb_ready, cmdb_we;
    logic [PW-1:0] cmdb_poly;
    logic [W-1:0]  wdb_data;
    logic          wdb_valid, wdb_ready;
    logic [W-1:0]  rd_data;
    logic          rd_valid, rd_id;
    logic          done, done_id, busy;
    logic          ram_wen;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [W-1:0]  ram_din, ram_dout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;

    typedef struct {
        int           t;
        logic         id;
        logic [AW-1:0] addr;
        logic [W-1:0] data;
    } ev_t;

    ev_t wr_q[$];
    ev_t rd_q[$];
    ev_t done_q[$];
    ev_t acc_q[$];
    int  busy_cnt, rdyb_cnt, wda_rdy_cnt, wdb_rdy_cnt;

    typedef struct {
        logic va;
        logic vb;
        logic exp_ra;
        logic exp_rb;
    } vec_t;

    vec_t vecs[4];

    polyvec_ram_arb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BEAT_BITS  (BB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmda_valid (cmda_valid),
        .cmda_ready (cmda_ready),
        .cmda_we    (cmda_we),
        .cmda_poly  (cmda_poly),
        .wda_data   (wda_data),
        .wda_valid  (wda_valid),
        .wda_ready  (wda_ready),
        .cmdb_valid (cmdb_valid),
        .cmdb_ready (cmdb_ready),
        .cmdb_we    (cmdb_we),
        .cmdb_poly  (cmdb_poly),
        .wdb_data   (wdb_data),
        .wdb_valid  (wdb_valid),
        .wdb_ready  (wdb_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_id      (rd_id),
        .done       (done),
        .done_id    (done_id),
        .busy       (busy),
        .ram_wen    (ram_wen),
        .ram_waddr  (ram_waddr),
        .ram_din    (ram_din),
        .ram_raddr  (ram_raddr),
        .ram_dout   (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: word i preloaded with i on the first edge, written thereafter.
    logic [W-1:0] mem [256];
    bit preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= W'(i);
            preloaded <= 1'b1;
        end else if (ram_wen) begin
            mem[ram_waddr] <= ram_din;
        end
    end
    assign ram_dout = mem[ram_raddr];

    always @(negedge clk) begin
        ev_t e;
        e.t    = cyc - base;
        e.id   = 1'b0;
        e.addr = '0;
        e.data = '0;
        if (ram_wen) begin
            e.addr = ram_waddr;
            e.data = ram_din;
            wr_q.push_back(e);
        end
        if (rd_valid) begin
            e.addr = '0;
            e.data = rd_data;
            e.id   = rd_id;
            rd_q.push_back(e);
        end
        if (done) begin
            e.data = '0;
            e.id   = done_id;
            done_q.push_back(e);
        end
        if (cmda_valid && cmda_ready) begin
            e.id = 1'b0;
            acc_q.push_back(e);
        end
        if (cmdb_valid && cmdb_ready) begin
            e.id = 1'b1;
            acc_q.push_back(e);
        end
        if (busy)      busy_cnt++;
        if (cmdb_ready) rdyb_cnt++;
        if (wda_ready) wda_rdy_cnt++;
        if (wdb_ready) wdb_rdy_cnt++;
    end

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_q.delete();
        rd_q.delete();
        done_q.delete();
        acc_q.delete();
        busy_cnt    = 0;
        rdyb_cnt    = 0;
        wda_rdy_cnt = 0;
        wdb_rdy_cnt = 0;
        base        = cyc;
    endtask

    task automatic idle_inputs();
        cmda_valid = 1'b0; cmda_we = 1'b0; cmda_poly = '0;
        cmdb_valid = 1'b0; cmdb_we = 1'b0; cmdb_poly = '0;
        wda_valid  = 1'b0; wda_data = '0;
        wdb_valid  = 1'b0; wdb_data = '0;
    endtask

    // Raise both requests briefly in IDLE, look at the grant, then withdraw before the edge.
    task automatic apply_stimulus(input string name, input logic va, input logic vb,
                                  input logic exp_ra, input logic exp_rb);
        cmda_valid = va;
        cmdb_valid = vb;
        cmda_we    = 1'b0;
        cmdb_we    = 1'b0;
        #1;
        check_output({name, "_ready_a"}, W'(cmda_ready), W'(exp_ra));
        check_output({name, "_ready_b"}, W'(cmdb_ready), W'(exp_rb));
        #1;
        cmda_valid = 1'b0;
        cmdb_valid = 1'b0;
        step();
    endtask

    task automatic check_writes(input string tag, input logic [AW-1:0] addr0, input logic [W-1:0] data0,
                                input int first_t, input int stall_at, input int stall_len);
        int exp_t;
        check_output({tag, "_count"}, W'(wr_q.size()), W'(64));
        for (int k = 0; k < 64 && k < wr_q.size(); k++) begin
            exp_t = first_t + k + ((k >= stall_at) ? stall_len : 0);
            check_output($sformatf("%s_addr[%0d]", tag, k), W'(wr_q[k].addr), W'(addr0 + AW'(k)));
            check_output($sformatf("%s_data[%0d]", tag, k), wr_q[k].data, data0 + W'(k));
            check_output($sformatf("%s_cyc[%0d]", tag, k), W'(wr_q[k].t), W'(exp_t));
        end
    endtask

    task automatic check_reads(input string tag, input int count, input logic [W-1:0] data0,
                               input logic id, input int first_t);
        check_output({tag, "_count"}, W'(rd_q.size()), W'(count));
        for (int k = 0; k < count && k < rd_q.size(); k++) begin
            check_output($sformatf("%s_data[%0d]", tag, k), rd_q[k].data, data0 + W'(k));
            check_output($sformatf("%s_id[%0d]", tag, k), W'(rd_q[k].id), W'(id));
            check_output($sformatf("%s_cyc[%0d]", tag, k), W'(rd_q[k].t), W'(first_t + k));
        end
    endtask

    task automatic check_done(input string tag, input int idx, input int exp_t, input logic exp_id);
        if (done_q.size() > idx) begin
            check_output({tag, "_cyc"}, W'(done_q[idx].t), W'(exp_t));
            check_output({tag, "_id"}, W'(done_q[idx].id), W'(exp_id));
        end else begin
            check_output({tag, "_present"}, W'(done_q.size()), W'(idx + 1));
        end
    endtask

    task automatic check_accept(input string tag, input int idx, input int exp_t, input logic exp_id);
        if (acc_q.size() > idx) begin
            check_output({tag, "_cyc"}, W'(acc_q[idx].t), W'(exp_t));
            check_output({tag, "_id"}, W'(acc_q[idx].id), W'(exp_id));
        end else begin
            check_output({tag, "_present"}, W'(acc_q.size()), W'(idx + 1));
        end
    endtask

    initial begin
        int k;
        int w;
        logic stall;

        vecs[0] = '{va: 1'b0, vb: 1'b0, exp_ra: 1'b0, exp_rb: 1'b0};
        vecs[1] = '{va: 1'b1, vb: 1'b0, exp_ra: 1'b1, exp_rb: 1'b0};
        vecs[2] = '{va: 1'b0, vb: 1'b1, exp_ra: 1'b0, exp_rb: 1'b1};
        vecs[3] = '{va: 1'b1, vb: 1'b1, exp_ra: 1'b1, exp_rb: 1'b0};

        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        check_output("rst_busy",     W'(busy),      '0);
        check_output("rst_rd_valid", W'(rd_valid),  '0);
        check_output("rst_rd_data",  rd_data,       '0);
        check_output("rst_rd_id",    W'(rd_id),     '0);
        check_output("rst_done",     W'(done),      '0);
        check_output("rst_done_id",  W'(done_id),   '0);
        check_output("rst_ram_wen",  W'(ram_wen),   '0);
        check_output("rst_waddr",    W'(ram_waddr), '0);
        check_output("rst_raddr",    W'(ram_raddr), '0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            apply_stimulus($sformatf("idle_vec%0d", i), vecs[i].va, vecs[i].vb,
                           vecs[i].exp_ra, vecs[i].exp_rb);
        end

        // a writes poly 2 while b holds a read of poly 1 pending; b's write port is noise.
        clear_logs();
        for (int t = 0; t < 140; t++) begin
            cmda_valid = (t == 0);
            cmda_we    = 1'b1;
            cmda_poly  = 2'd2;
            cmdb_valid = (t <= 65);
            cmdb_we    = 1'b0;
            cmdb_poly  = 2'd1;
            wda_valid  = (t >= 1 && t <= 64);
            wda_data   = DATA_A + W'(t) - W'(1);
            wdb_valid  = 1'b1;
            wdb_data   = '1;
            step();
        end
        idle_inputs();
        check_output("s1_accepts", W'(acc_q.size()), W'(2));
        check_accept("s1_acc_a", 0, 0, 1'b0);
        check_accept("s1_acc_b", 1, 65, 1'b1);
        check_writes("s1_wr", 8'h80, DATA_A, 1, 64, 0);
        check_output("s1_dones", W'(done_q.size()), W'(2));
        check_done("s1_done_a", 0, 65, 1'b0);
        check_done("s1_done_b", 1, 130, 1'b1);
        check_reads("s1_rd", 64, W'(64), 1'b1, 67);
        check_output("s1_busy_cycles",    W'(busy_cnt),    W'(128));
        check_output("s1_cmdb_ready_cyc", W'(rdyb_cnt),    W'(1));
        check_output("s1_wdb_ready_cyc",  W'(wdb_rdy_cnt), W'(0));
        check_output("s1_wda_ready_cyc",  W'(wda_rdy_cnt), W'(64));

        apply_stimulus("tie_after_b", 1'b1, 1'b1, 1'b1, 1'b0);

        // a writes poly 3 with its data valid withdrawn on WR cycles 10..14.
        clear_logs();
        k = 0;
        for (int t = 0; t < 80; t++) begin
            cmda_valid = (t == 0);
            cmda_we    = 1'b1;
            cmda_poly  = 2'd3;
            w          = t - 1;
            stall      = (w >= 10 && w <= 14);
            wda_valid  = (t >= 1) && !stall && (k < 64);
            wda_data   = DATA_C + W'(k);
            step();
            if (wda_valid) k++;
        end
        idle_inputs();
        check_accept("s2_acc_a", 0, 0, 1'b0);
        check_writes("s2_wr", 8'hC0, DATA_C, 1, 10, 5);
        check_output("s2_dones", W'(done_q.size()), W'(1));
        check_done("s2_done", 0, 70, 1'b0);
        check_output("s2_busy_cycles", W'(busy_cnt), W'(69));

        apply_stimulus("tie_after_a", 1'b1, 1'b1, 1'b0, 1'b1);

        // a reads poly 1 and is reset while beat 30 is on the address bus.
        clear_logs();
        for (int t = 0; t < 31; t++) begin
            cmda_valid = (t == 0);
            cmda_we    = 1'b0;
            cmda_poly  = 2'd1;
            step();
        end
        idle_inputs();
        check_output("s3_pre_raddr", W'(ram_raddr), W'(8'h5E));
        rst_n = 1'b0;
        #1;
        check_output("s3_rst_rd_valid", W'(rd_valid),  '0);
        check_output("s3_rst_done",     W'(done),      '0);
        check_output("s3_rst_busy",     W'(busy),      '0);
        check_output("s3_rst_raddr",    W'(ram_raddr), '0);
        step();
        step();
        check_reads("s3_rd", 29, W'(64), 1'b0, 2);
        check_output("s3_dones", W'(done_q.size()), W'(0));
        rst_n = 1'b1;
        step();

        apply_stimulus("tie_after_rst", 1'b1, 1'b1, 1'b1, 1'b0);

        clear_logs();
        for (int t = 0; t < 70; t++) begin
            cmda_valid = (t == 0);
            cmda_we    = 1'b0;
            cmda_poly  = 2'd1;
            step();
        end
        idle_inputs();
        check_accept("s4_acc_a", 0, 0, 1'b0);
        check_reads("s4_rd", 64, W'(64), 1'b0, 2);
        check_output("s4_dones", W'(done_q.size()), W'(1));
        check_done("s4_done", 0, 65, 1'b0);
        check_output("s4_busy_cycles", W'(busy_cnt), W'(64));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/polyvec_ram_arb.md
POLYVEC_RAM_ARB -- requirements
Module: polyvec_ram_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, RAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 23, coefficient width; one RAM word is 4 coefficients (W = 4*DATA_WIDTH).
REQ-003 SHALL have parameter BEAT_BITS, default 6, log2 of RAM words per polynomial (64 words = 256 coefficients).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cmdX_valid  in  1  (X = a, b) requester X transfer request.
REQ-007 cmdX_ready  out  1  request accepted this cycle.
REQ-008 cmdX_we  in  1  1 = write polynomial, 0 = read polynomial.
REQ-009 cmdX_poly  in  ADDR_WIDTH-BEAT_BITS  polynomial slot index.
REQ-010 wdX_data  in  W  write beat, coefficient 0 in bits [DATA_WIDTH-1:0].
REQ-011 wdX_valid  in  1 / wdX_ready  out  1  write-beat handshake.
REQ-012 rd_data  out  W / rd_valid  out  1 / rd_id  out  1 (0 = a, 1 = b)  read beat; no backpressure.
REQ-013 done  out  1 / done_id  out  1  one-cycle end-of-transfer pulse with owner.
REQ-014 busy  out  1  high while state is not IDLE.
REQ-015 ram_wen  out  1 / ram_waddr  out  ADDR_WIDTH / ram_din  out  W  RAM write port.
REQ-016 ram_raddr  out  ADDR_WIDTH / ram_dout  in  W  RAM read port; read data is combinational from address.

Function
REQ-017 SHALL implement FSM states IDLE, WR, RD.
REQ-018 In IDLE, at most one cmdX_ready SHALL be high; if only one cmdX_valid is high, that requester is granted.
REQ-019 If both valid in IDLE, grant SHALL go to the requester not granted last (round-robin pointer); pointer updates only on acceptance.
REQ-020 cmdX_ready SHALL be combinational, high only in IDLE for the selected requester, and only when cmdX_valid is high.
REQ-021 On acceptance SHALL latch owner, we and poly, clear beat counter to 0, and enter WR (we=1) or RD (we=0) next cycle.
REQ-022 RAM address SHALL be {poly, beat} in both WR and RD; no wrap beyond the slot is possible.
REQ-023 In WR, wdX_ready SHALL be high only for the owner; the non-owner's wdX_ready is 0.
REQ-024 In WR, each cycle with owner wdX_valid high: ram_wen=1, ram_din=owner wdX_data, ram_waddr={poly,beat}, beat++; with wdX_valid low, ram_wen=0 and beat holds (stall, unbounded).
REQ-025 In RD, ram_raddr={poly,beat} every cycle; ram_dout SHALL be registered into rd_data with rd_valid=1, rd_id=owner on the next cycle; beat++ every cycle.
REQ-026 Transfer SHALL end on the beat with beat = 2^BEAT_BITS-1; FSM returns to IDLE next cycle.
REQ-027 done SHALL pulse exactly one cycle, in the cycle after the final beat, with done_id=owner; for reads it coincides with the last rd_valid.
REQ-028 A new command SHALL be acceptable in the same cycle as done (back-to-back transfers, no idle bubble beyond that cycle).
REQ-029 Read latency: command accept edge to first rd_valid = 2 cycles; 64 consecutive rd_valid beats.
REQ-030 ram_wen SHALL be 0 outside WR; outside WR/RD ram_waddr and ram_raddr SHALL be 0.
REQ-031 cmd inputs from the non-owner during a transfer SHALL be ignored (held pending, not lost by the arbiter).

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, beat=0, owner=0, rr pointer so that a wins the first tie, rd_data=0, rd_valid=0, rd_id=0, done=0, done_id=0.
REQ-033 Reset mid-transfer SHALL abort it with no done pulse; RAM contents are unaffected by the controller beyond beats already written.

Verification
REQ-034 a write poly=2, 64 beats continuous -> ram_wen on 64 cycles, addresses 0x80..0xBF, done=1 done_id=0 one cycle after address 0xBF.
REQ-035 a and b request simultaneously after reset -> a granted first; on done b accepted same cycle; next tie -> a wins only after b was granted.
REQ-036 b read poly=1 with RAM model preloaded word i = i -> rd_valid 2 cycles after accept, rd_data 0x40..0x7F in order, rd_id=1, done with last beat.
REQ-037 a write with wda_valid deasserted on beats 10-14 -> ram_wen low those cycles, beat holds, total 64 writes, no address skipped or repeated.
REQ-038 rst_n low at beat 30 of a read -> rd_valid, done, busy 0 immediately; after release, new command accepted, beats restart at 0.
REQ-039 b valid throughout a's transfer -> cmdb_ready stays 0 until a's done cycle, wdb_ready 0 during a's write.
